clock_divider_multi: RTL and testbench

//  Next-generation GPU timing divider: CHANNELS independent clock-enable generators from one clk.

---
 rtl/clock_divider_multi_if.sv | 16 +
 rtl/clock_divider_multi.sv | 89 ++++++++
 tb/tb_clock_divider_multi.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_multi_if.sv
// rtl/clock_divider_multi_if.sv - divisor write / sync control bus for clock_divider_multi
`timescale 1ns/1ps
interface clock_divider_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CH_W     = 2
);
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_div;
    logic                sync_in;
    logic [CHANNELS-1:0] pending;

    modport master (output wr_en, output wr_ch, output wr_div, output sync_in, input pending);
    modport slave  (input wr_en, input wr_ch, input wr_div, input sync_in, output pending);
endinterface

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable clock-enable divider
`timescale 1ns/1ps
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    clock_divider_multi_if.slave      cfg,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS*WIDTH-1:0] sub_count
);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
    logic [CHANNELS-1:0][WIDTH-1:0] pdiv_q, pdiv_d;
    logic [CHANNELS-1:0]            pending_q, pending_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            level_q, level_d;
    logic [CHANNELS-1:0]            running, wrap, apply, hit;
    logic [CHANNELS-1:0][WIDTH:0]   half;

    always_comb begin
        count_d   = count_q;
        active_d  = active_q;
        pdiv_d    = pdiv_q;
        pending_d = pending_q;
        tick_d    = '0;
        level_d   = '0;
        running   = '0;
        wrap      = '0;
        apply     = '0;
        hit       = '0;
        half      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            running[c] = (active_q[c] != '0);
            wrap[c]    = running[c] && (count_q[c] == active_q[c] - WIDTH'(1));
            hit[c]     = cfg.wr_en && (cfg.wr_ch == CH_W'(c));
            // Sync and a stopped channel both take the pending divisor right away.
            if (cfg.sync_in || !running[c]) begin
                apply[c]   = pending_q[c];
                count_d[c] = '0;
            end else begin
                apply[c]   = wrap[c] && pending_q[c];
                count_d[c] = wrap[c] ? '0 : count_q[c] + WIDTH'(1);
            end
            if (apply[c]) begin
                active_d[c] = pdiv_q[c];
            end
            tick_d[c]  = cfg.sync_in ? (active_d[c] != '0) : wrap[c];
            half[c]    = ({1'b0, active_d[c]} + (WIDTH+1)'(1)) >> 1;
            level_d[c] = (active_d[c] != '0) && ({1'b0, count_d[c]} < half[c]);
            // A write landing on an apply edge stays pending for the next boundary.
            if (hit[c]) begin
                pending_d[c] = 1'b1;
                pdiv_d[c]    = cfg.wr_div;
            end else if (apply[c]) begin
                pending_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            active_q  <= {CHANNELS{DEF_DIV}};
            pdiv_q    <= '0;
            pending_q <= '0;
            tick_q    <= '0;
            level_q   <= '0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            pdiv_q    <= pdiv_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
        end
    end

    assign tick        = tick_q;
    assign level       = level_q;
    assign sub_count   = count_q;
    assign cfg.pending = pending_q;
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - self-checking bench for clock_divider_multi
`timescale 1ns/1ps
module tb_clock_divider_multi;
    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int CW  = 2;
    localparam int DEF = 2;
    localparam int VW  = 3*CH + CH*W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   tick, level;
    logic [CH*W-1:0] sub_count;

    clock_divider_multi_if #(.CHANNELS(CH), .WIDTH(W), .CH_W(CW)) bus();

    clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .CH_W(CW), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .cfg(bus), .tick(tick), .level(level), .sub_count(sub_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: per-channel position in period, divisor, and pending write.
    int m_cnt[CH], m_div[CH], m_pend[CH], m_pdiv[CH], m_tick[CH];
    bit m_fresh;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_div[c] = DEF; m_pend[c] = 0; m_pdiv[c] = 0; m_tick[c] = 0;
        end
        m_fresh = 1;
    endtask

    task automatic model_step(input bit we, input int ch, input int d, input bit sy);
        for (int c = 0; c < CH; c++) begin
            int  nd;
            bit  took;
            if (sy) begin
                took = m_pend[c] != 0;
                nd = took ? m_pdiv[c] : m_div[c];
                m_cnt[c] = 0;
                m_tick[c] = (nd != 0);
            end else if (m_div[c] == 0) begin
                took = m_pend[c] != 0;
                nd = took ? m_pdiv[c] : 0;
                m_cnt[c] = 0;
                m_tick[c] = 0;
            end else begin
                bit end_of_period;
                end_of_period = (m_cnt[c] == m_div[c] - 1);
                m_tick[c] = end_of_period;
                m_cnt[c]  = end_of_period ? 0 : m_cnt[c] + 1;
                took = end_of_period && (m_pend[c] != 0);
                nd = took ? m_pdiv[c] : m_div[c];
            end
            m_div[c] = nd;
            if (took) m_pend[c] = 0;
            if (we && ch == c) begin
                m_pend[c] = 1;
                m_pdiv[c] = d;
            end
        end
        m_fresh = 0;
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [CH-1:0]   t, l, p;
        logic [CH*W-1:0] s;
        for (int c = 0; c < CH; c++) begin
            t[c] = (m_tick[c] != 0);
            l[c] = !m_fresh && (m_div[c] != 0) && (m_cnt[c] < (m_div[c] + 1) / 2);
            p[c] = (m_pend[c] != 0);
            s[c*W +: W] = W'(m_cnt[c]);
        end
        return {t, l, s, p};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {tick, level, sub_count, bus.pending};
    endfunction

    task automatic cyc(input bit we, input int ch, input int d, input bit sy);
        bus.wr_en   = we;
        bus.wr_ch   = CW'(ch);
        bus.wr_div  = W'(d);
        bus.sync_in = sy;
        @(posedge clk);
        model_step(we, ch, d, sy);
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.sync_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_ch = '0; bus.wr_div = '0; bus.sync_in = 0;
        rst = 0;
        #12;
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic test_default();
        for (int i = 1; i <= 8; i++) begin
            logic [CH-1:0] want;
            cyc(0, 0, 0, 0);
            want = (i % 2 == 0) ? '1 : '0;
            n_checks++;
            if (tick !== want || level !== want) begin
                n_fail++;
                $display("FAIL default_div edge %0d: tick=%b level=%b want %b", i, tick, level, want);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL default_model edge %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_write_mid();
        int ticks, highs;
        cyc(0, 0, 0, 0);
        cyc(1, 1, 5, 0);
        n_checks++;
        if (bus.pending !== 3'b010) begin
            n_fail++;
            $display("FAIL write_pending: got %b want 010", bus.pending);
        end
        for (int i = 0; i < 4 && bus.pending[1]; i++) cyc(0, 0, 0, 0);
        n_checks++;
        if (bus.pending[1] !== 1'b0 || tick[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_apply: pending=%b tick=%b want pending[1]=0 tick[1]=1", bus.pending, tick);
        end
        ticks = 0; highs = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 0, 0);
            ticks += int'(tick[1]);
            highs += int'(level[1]);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL write_model cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (ticks != 3 || highs != 9) begin
            n_fail++;
            $display("FAIL n5_shape: ticks=%0d highs=%0d want 3 and 9", ticks, highs);
        end
    endtask

    task automatic test_stop_restart();
        int ticks;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4 && bus.pending[0]; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            n_checks++;
            if (tick[0] !== 1'b0 || level[0] !== 1'b0 || sub_count[W-1:0] !== '0 || bus.pending[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL stopped cyc %0d: tick=%b level=%b cnt=%0d pend=%b want all 0",
                         i, tick[0], level[0], sub_count[W-1:0], bus.pending[0]);
            end
        end
        cyc(1, 0, 3, 0);
        cyc(0, 0, 0, 0);
        n_checks++;
        if (bus.pending[0] !== 1'b0 || sub_count[W-1:0] !== '0 || level[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_apply: pend=%b cnt=%0d level=%b want 0,0,1",
                     bus.pending[0], sub_count[W-1:0], level[0]);
        end
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 0);
            ticks += int'(tick[0]);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL restart_model cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (ticks != 3) begin
            n_fail++;
            $display("FAIL restart_period: ticks=%0d want 3", ticks);
        end
    endtask

    task automatic test_sync();
        cyc(1, 0, 3, 0);
        cyc(1, 1, 4, 0);
        cyc(1, 2, 7, 0);
        for (int i = 0; i < 12 + int'($urandom_range(0, 9)); i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        n_checks++;
        if (sub_count !== '0 || tick !== 3'b111 || level !== 3'b111) begin
            n_fail++;
            $display("FAIL sync_align: cnt=%h tick=%b level=%b want 0,111,111", sub_count, tick, level);
        end
        for (int k = 1; k <= 28; k++) begin
            logic [CH-1:0] want;
            cyc(0, 0, 0, 0);
            want = {k % 7 == 0, k % 4 == 0, k % 3 == 0};
            n_checks++;
            if (tick !== want || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL sync_phase k=%0d: tick=%b want %b, got %h want %h",
                         k, tick, want, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_out_of_range();
        int gap;
        cyc(1, 3, 9, 0);
        n_checks++;
        if (bus.pending !== '0) begin
            n_fail++;
            $display("FAIL oor_pending: got %b want 000", bus.pending);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL oor_model cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 10 && !tick[2]; i++) cyc(0, 0, 0, 0);
        cyc(1, 2, 4, 0);
        cyc(1, 2, 6, 0);
        n_checks++;
        if (bus.pending[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL double_pending: got %b want 1", bus.pending[2]);
        end
        for (int i = 0; i < 10 && bus.pending[2]; i++) cyc(0, 0, 0, 0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            gap++;
            if (tick[2]) break;
        end
        n_checks++;
        if (gap != 6 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL double_write_period: gap=%0d want 6, got %h want %h", gap, dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 7, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        #2 rst = 0;
        #1;
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0", dut_vec());
        end
        model_reset();
        @(negedge clk);
        rst = 1;
        cyc(0, 0, 0, 0);
        n_checks++;
        if (tick !== 3'b000 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL post_reset edge1: tick=%b want 000, got %h want %h", tick, dut_vec(), model_vec());
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (tick !== 3'b111 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL post_reset edge2: tick=%b want 111, got %h want %h", tick, dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit we, sy;
            int ch, d;
            we = ($urandom_range(0, 3) == 0);
            sy = ($urandom_range(0, 29) == 0);
            ch = $urandom_range(0, 3);
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
            cyc(we, ch, d, sy);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_write_mid();
        test_stop_restart();
        test_sync();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
